// File: rtl/fixed_alu_pkg.sv
`default_nettype none
// ============================================================================
// fixed_alu_pkg : op codes, FSM states, latencies and narrowing helpers
// Rev 1.0
// ============================================================================
package fixed_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_DOT = 3'd4,
        OP_MIN = 3'd5,
        OP_MAX = 3'd6
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int LAT_ALU = 1;
    localparam int LAT_MUL = 2;
    localparam int LAT_DOT = 3;

    // Exact-result width; covers the 2W+2 bit DOT sum for any W up to 64.
    localparam int XW = 132;

    function automatic logic [7:0] op_latency(input op_e op, input int w, input int frac);
        case (op)
            OP_MUL:  return 8'(LAT_MUL);
            OP_DOT:  return 8'(LAT_DOT);
            OP_DIV:  return 8'(w + frac + 1);
            default: return 8'(LAT_ALU);
        endcase
    endfunction

    function automatic logic [XW-1:0] max_pos(input int w);
        return (XW'(1) << (w - 1)) - XW'(1);
    endfunction

    function automatic logic fixed_ovf(input logic [XW-1:0] v, input int w);
        logic [XW-1:0] maxv;
        maxv = max_pos(w);
        return ($signed(v) > $signed(maxv)) || ($signed(v) < $signed(~maxv));
    endfunction

    // Caller truncates the return value to w bits, so the pass-through case wraps.
    function automatic logic [XW-1:0] fixed_narrow(input logic [XW-1:0] v, input int w,
                                                   input logic sat);
        logic [XW-1:0] maxv;
        maxv = max_pos(w);
        if (sat && fixed_ovf(v, w)) begin
            return v[XW-1] ? ~maxv : maxv;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_div_iter.sv
`default_nettype none
// ============================================================================
// fixed_div_iter : restoring signed fixed-point divider, one quotient bit/cycle
// Rev 1.0
// ============================================================================
module fixed_div_iter
    import fixed_alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [W-1:0]    dividend,
    input  logic [W-1:0]    divisor,
    output logic            done,
    output logic [W+FRAC:0] quotient,
    output logic            div0
);

    localparam int NB = W + FRAC;
    localparam int CW = $clog2(NB + 1);

    logic [NB-1:0] num_q;
    logic [NB-1:0] quo_q;
    logic [W-1:0]  den_q;
    logic [W-1:0]  rem_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          neg_q;
    logic          nega_q;
    logic          zero_q;

    logic [W-1:0]  w_mag_a;
    logic [W-1:0]  w_mag_b;
    logic [W:0]    w_trial;
    logic          w_take;

    assign w_mag_a = dividend[W-1] ? -dividend : dividend;
    assign w_mag_b = divisor[W-1]  ? -divisor  : divisor;
    assign w_trial = {rem_q, num_q[NB-1]};
    assign w_take  = (w_trial >= {1'b0, den_q});

    always_ff @(posedge clk) begin
        if (!resetn) begin
            num_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            nega_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (start) begin
            num_q  <= {w_mag_a, {FRAC{1'b0}}};
            den_q  <= w_mag_b;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= CW'(NB);
            busy_q <= 1'b1;
            neg_q  <= dividend[W-1] ^ divisor[W-1];
            nega_q <= dividend[W-1];
            zero_q <= (divisor == '0);
        end else if (busy_q) begin
            num_q <= {num_q[NB-2:0], 1'b0};
            quo_q <= {quo_q[NB-2:0], w_take};
            rem_q <= w_take ? W'(w_trial - {1'b0, den_q}) : w_trial[W-1:0];
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Zero divisor reports the W-bit extreme matching the dividend sign.
    always_comb begin
        quotient = {1'b0, quo_q};
        if (zero_q) begin
            quotient = nega_q ? {{(FRAC+2){1'b1}}, {(W-1){1'b0}}}
                              : {{(FRAC+2){1'b0}}, {(W-1){1'b1}}};
        end else if (neg_q) begin
            quotient = -{1'b0, quo_q};
        end
    end

    assign done = ~busy_q;
    assign div0 = zero_q;

endmodule
`default_nettype wire

// File: rtl/fixed_vec_alu.sv
`default_nettype none
// ============================================================================
// fixed_vec_alu : multi-lane signed fixed-point ALU (ADD/SUB/MUL/DIV/DOT/MIN/MAX)
// Define FIXED_VEC_ALU_SAT_EN to clamp overflowing lanes instead of wrapping.
// Rev 1.0
// ============================================================================
module fixed_vec_alu
    import fixed_alu_pkg::*;
#(
    parameter int LANES = 3,
    parameter int W     = 32,
    parameter int FRAC  = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      strobe,
    input  logic [2:0]                op,
    input  logic [LANES-1:0][W-1:0]   a,
    input  logic [LANES-1:0][W-1:0]   b,
    output logic [LANES-1:0][W-1:0]   out,
    output logic                      valid,
    output logic                      free,
    output logic [LANES-1:0]          ovf,
    output logic                      div0
);

`ifdef FIXED_VEC_ALU_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_e                    state_q;
    logic [7:0]                cnt_q;
    op_e                       op_q;
    logic [LANES-1:0][W-1:0]   a_q;
    logic [LANES-1:0][W-1:0]   b_q;
    logic [LANES-1:0][W-1:0]   out_q;
    logic                      valid_q;
    logic [LANES-1:0]          ovf_q;
    logic                      div0_q;

    logic [LANES-1:0][2*W-1:0] prod_q;
    logic [2*W+1:0]            sum_q;
    logic [2*W+1:0]            sum_d;
    logic [2*W+1:0]            w_dot_sh;
    logic [XW-1:0]             w_dotx;

    logic [LANES-1:0][W-1:0]   res_d;
    logic [LANES-1:0]          ovf_d;

    logic                      w_div_start;
    logic [LANES-1:0]          w_div_done;
    logic [LANES-1:0]          w_div0;
    logic [LANES-1:0][W+FRAC:0] w_quo;
    logic                      w_done_ok;

    assign free        = (state_q == S_IDLE);
    assign w_div_start = strobe && free && (op == OP_DIV);
    assign w_done_ok   = (op_q != OP_DIV) || (&w_div_done);

    // Product and dot-sum pipeline free-runs off the held operands.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= {{W{a_q[i][W-1]}}, a_q[i]} * {{W{b_q[i][W-1]}}, b_q[i]};
        end
        sum_q <= sum_d;
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + {{2{prod_q[i][2*W-1]}}, prod_q[i]};
        end
    end

    assign w_dot_sh = $signed(sum_q) >>> FRAC;
    assign w_dotx   = {{(XW-2*W-2){w_dot_sh[2*W+1]}}, w_dot_sh};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [XW-1:0]  w_ax;
        logic [XW-1:0]  w_bx;
        logic [2*W-1:0] w_mul_sh;
        logic [XW-1:0]  w_mulx;
        logic [XW-1:0]  w_qx;
        logic [XW-1:0]  exact_d;

        assign w_ax     = {{(XW-W){a_q[i][W-1]}}, a_q[i]};
        assign w_bx     = {{(XW-W){b_q[i][W-1]}}, b_q[i]};
        assign w_mul_sh = $signed(prod_q[i]) >>> FRAC;
        assign w_mulx   = {{(XW-2*W){w_mul_sh[2*W-1]}}, w_mul_sh};
        assign w_qx     = {{(XW-W-FRAC-1){w_quo[i][W+FRAC]}}, w_quo[i]};

        fixed_div_iter #(
            .W    (W),
            .FRAC (FRAC)
        ) u_div (
            .clk      (clk),
            .resetn   (resetn),
            .start    (w_div_start),
            .dividend (a[i]),
            .divisor  (b[i]),
            .done     (w_div_done[i]),
            .quotient (w_quo[i]),
            .div0     (w_div0[i])
        );

        always_comb begin
            exact_d = '0;
            case (op_q)
                OP_ADD:  exact_d = w_ax + w_bx;
                OP_SUB:  exact_d = w_ax - w_bx;
                OP_MUL:  exact_d = w_mulx;
                OP_DIV:  exact_d = w_qx;
                OP_DOT:  exact_d = (i == 0) ? w_dotx : '0;
                OP_MIN:  exact_d = ($signed(a_q[i]) < $signed(b_q[i])) ? w_ax : w_bx;
                OP_MAX:  exact_d = ($signed(a_q[i]) > $signed(b_q[i])) ? w_ax : w_bx;
                default: exact_d = '0;
            endcase
        end

        assign res_d[i] = W'(fixed_narrow(exact_d, W, SAT_EN));
        assign ovf_d[i] = fixed_ovf(exact_d, W);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (strobe) begin
                        op_q    <= op_e'(op);
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= op_latency(op_e'(op), W, FRAC);
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 8'd1 && w_done_ok) begin
                        out_q   <= res_d;
                        ovf_q   <= ovf_d;
                        div0_q  <= (op_q == OP_DIV) && (|w_div0);
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q > 8'd1) begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
            endcase
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign div0  = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_vec_alu.sv
`default_nettype none
// ============================================================================
// tb_fixed_vec_alu : directed vectors with a scoreboard queue and result monitor
// Rev 1.0
// ============================================================================
module tb_fixed_vec_alu;

    localparam int LANES = 3;
    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int LDIV  = W + FRAC + 1;

`ifdef FIXED_VEC_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [LANES-1:0][W-1:0] vec_t;
    typedef struct {
        vec_t             out;
        logic [LANES-1:0] ovf;
        logic             div0;
        int               due;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             strobe;
    logic [2:0]       op;
    vec_t             a;
    vec_t             b;
    vec_t             out;
    logic             valid;
    logic             free;
    logic [LANES-1:0] ovf;
    logic             div0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    exp_t mon_e;

    fixed_vec_alu #(.LANES(LANES), .W(W), .FRAC(FRAC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .strobe (strobe),
        .op     (op),
        .a      (a),
        .b      (b),
        .out    (out),
        .valid  (valid),
        .free   (free),
        .ovf    (ovf),
        .div0   (div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pops one expectation; overdue entries count as failures.
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid=1 at cycle %0d expected no pending result", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check({mon_e.name, "_out"}, 128'(out), 128'(mon_e.out));
                    check({mon_e.name, "_ovf"}, 128'(ovf), 128'(mon_e.ovf));
                    check({mon_e.name, "_div0"}, 128'(div0), 128'(mon_e.div0));
                    check({mon_e.name, "_cycle"}, 128'(cyc), 128'(mon_e.due));
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
                mon_e = sbq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: got no valid by cycle %0d expected valid at cycle %0d",
                         mon_e.name, cyc, mon_e.due);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input string name, input logic [2:0] opc, input vec_t va, input vec_t vb,
                         input int lat, input vec_t eout, input logic [LANES-1:0] eovf,
                         input logic ediv0, input bit push);
        exp_t e;
        int   n;
        n = 0;
        while (free !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_free_timeout: got free=%b expected 1 within 200 cycles", name, free);
                return;
            end
        end
        strobe = 1'b1;
        op     = opc;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        if (push) begin
            e.out  = eout;
            e.ovf  = eovf;
            e.div0 = ediv0;
            e.due  = cyc + lat;
            e.name = name;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running at %0t expected finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        resetn = 1'b0;
        strobe = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 128'(out), 128'(0));
        check("rst_valid", 128'(valid), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check("rst_div0", 128'(div0), 128'(0));
        check("rst_free", 128'(free), 128'(1));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue("add", 3'd0, {32'h00010000, 32'hFFFF0000, 32'h00018000},
              {32'h00010000, 32'h00008000, 32'h00024000}, 1,
              {32'h00020000, 32'hFFFF8000, 32'h0003C000}, 3'b000, 1'b0, 1'b1);
        issue("sub", 3'd1, {32'h00050000, 32'h80000000, 32'h00010000},
              {32'h00050000, 32'h00000001, 32'h00030000}, 1,
              {32'h00000000, (SAT ? 32'h80000000 : 32'h7FFFFFFF), 32'hFFFE0000}, 3'b010, 1'b0, 1'b1);
        issue("mul", 3'd2, {32'hFFFFFFFF, 32'h00008000, 32'hFFFE0000},
              {32'h00008000, 32'h00008000, 32'h00030000}, 2,
              {32'hFFFFFFFF, 32'h00004000, 32'hFFFA0000}, 3'b000, 1'b0, 1'b1);

        // Strobe raised in the cycle the MUL result is presented.
        n = 0;
        while (free !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_valid_with_free", 128'(valid), 128'(1));
        issue("mul_b2b", 3'd2, {32'h80000000, 32'h00020000, 32'h01000000},
              {32'hFFFF0000, 32'h00020000, 32'h01000000}, 2,
              {(SAT ? 32'h7FFFFFFF : 32'h80000000), 32'h00040000, (SAT ? 32'h7FFFFFFF : 32'h00000000)},
              3'b101, 1'b0, 1'b1);
        issue("dot", 3'd4, {32'h00030000, 32'h00020000, 32'h00010000},
              {32'h00060000, 32'h00050000, 32'h00040000}, 3,
              {32'h00000000, 32'h00000000, 32'h00200000}, 3'b000, 1'b0, 1'b1);
        issue("min", 3'd5, {32'h00050000, 32'h80000000, 32'h00010000},
              {32'h00050000, 32'h7FFFFFFF, 32'hFFFF0000}, 1,
              {32'h00050000, 32'h80000000, 32'hFFFF0000}, 3'b000, 1'b0, 1'b1);
        issue("max", 3'd6, {32'h00050000, 32'h80000000, 32'h00010000},
              {32'h00050000, 32'h7FFFFFFF, 32'hFFFF0000}, 1,
              {32'h00050000, 32'h7FFFFFFF, 32'h00010000}, 3'b000, 1'b0, 1'b1);

        issue("div", 3'd3, {32'h00070000, 32'hFFFE0000, 32'h00010000},
              {32'h00020000, 32'h00008000, 32'h00030000}, LDIV,
              {32'h00038000, 32'hFFFC0000, 32'h00005555}, 3'b000, 1'b0, 1'b1);
        strobe = 1'b1;
        op     = 3'd0;
        a      = {3{32'h11110000}};
        b      = {3{32'h22220000}};
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        strobe = 1'b0;

        issue("div0", 3'd3, {32'h00010000, 32'hFFFF0000, 32'h00050000},
              {32'h00010000, 32'h00000000, 32'h00000000}, LDIV,
              {32'h00010000, 32'h80000000, 32'h7FFFFFFF}, 3'b000, 1'b1, 1'b1);
        issue("add_ovf", 3'd0, {32'h00000000, 32'h80000000, 32'h7FFF0000},
              {32'h00000000, 32'hFFFF0000, 32'h00020000}, 1,
              {32'h00000000, (SAT ? 32'h80000000 : 32'h7FFF0000), (SAT ? 32'h7FFFFFFF : 32'h80010000)},
              3'b011, 1'b0, 1'b1);
        issue("unused_op", 3'd7, {32'h00030000, 32'h7FFF0000, 32'h00010000},
              {32'h00010000, 32'h7FFF0000, 32'h00000000}, 1,
              {32'h0, 32'h0, 32'h0}, 3'b000, 1'b0, 1'b1);
        wait_idle();

        // Abort a DIV with reset at its tenth cycle; no result may appear.
        issue("div_abort", 3'd3, {32'h00010000, 32'h00010000, 32'h00050000},
              {32'h00010000, 32'h00010000, 32'h00010000}, LDIV,
              {32'h0, 32'h0, 32'h0}, 3'b000, 1'b0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("abort_free", 128'(free), 128'(1));
        check("abort_valid", 128'(valid), 128'(0));
        repeat (LDIV + 5) begin
            @(posedge clk);
            #1;
        end
        issue("add_after_rst", 3'd0, {32'h00030000, 32'h00020000, 32'h00010000},
              {32'h00010000, 32'h00010000, 32'h00010000}, 1,
              {32'h00040000, 32'h00030000, 32'h00020000}, 3'b000, 1'b0, 1'b1);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
